fpdiv_arbiter: RTL and testbench

- Shares one iterative fpdiv divide/sqrt unit between NREQ requesters, e.g. two issue ports of the FP cluster.
- Arbitrates round-robin and latches the winner's operation.
- Pulses start into fpdiv and waits for its done pulse, with a watchdog timeout.
- Returns the result, tagged with the requester ID, over a valid/ready response channel.

---
 rtl/fpdiv_pkg.sv | 24 ++
 rtl/fpdiv_arbiter_rr.sv | 35 +++
 rtl/fpdiv_arbiter.sv | 135 +++++++++++++
 tb/tb_fpdiv_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// rtl/fpdiv_pkg.sv - shared types and constants for the fpdiv request arbiter
package fpdiv_pkg;

   localparam logic [1:0]  OP_DIV  = 2'b00;
   localparam logic [1:0]  OP_SQRT = 2'b01;
   localparam logic [31:0] QNAN32  = 32'h7FC00000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY,
      RESP
   } state_t;

   // id is sized for the largest supported requester count (8)
   typedef struct packed {
      logic [1:0]  op;
      logic        rm;
      logic [31:0] x;
      logic [31:0] d;
      logic [2:0]  id;
   } req_t;

endpackage

// File: rtl/fpdiv_arbiter_rr.sv
// rtl/fpdiv_arbiter_rr.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   logic [IDW:0] j;

   // Scan from the farthest offset down so the nearest valid slot wins last.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = {1'b0, ptr} + (IDW+1)'(k);
         if (j >= (IDW+1)'(NREQ)) begin
            j = j - (IDW+1)'(NREQ);
         end
         if (valid[j[IDW-1:0]]) begin
            grant             = '0;
            grant[j[IDW-1:0]] = 1'b1;
            idx               = j[IDW-1:0];
            any               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpdiv_arbiter.sv
// rtl/fpdiv_arbiter.sv - shares one iterative divide/sqrt unit among NREQ requesters
module fpdiv_arbiter
   import fpdiv_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 64,
   parameter int CNTW    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [2*NREQ-1:0]       req_op,
   input  logic [NREQ-1:0]         req_rm,
   input  logic [32*NREQ-1:0]      req_x,
   input  logic [32*NREQ-1:0]      req_d,
   output logic                    div_start,
   output logic [1:0]              div_op,
   output logic                    div_rm,
   output logic [31:0]             div_x,
   output logic [31:0]             div_d,
   input  logic                    div_done,
   input  logic [31:0]             div_result,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [31:0]             rsp_result,
   output logic                    rsp_err,
   output logic [CNTW-1:0]         cnt_done,
   output logic [CNTW-1:0]         cnt_err
);

   localparam int IDW = $clog2(NREQ);
   localparam int TW  = $clog2(TIMEOUT + 1);

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [TW-1:0]   timer;
   req_t            cur;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gidx;
   logic            any;
   logic [1:0]      g_op;
   logic [31:0]     g_x;
   logic [31:0]     g_d;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (any)
   );

   assign req_ready = (reset && state == IDLE) ? grant : '0;

   assign g_op = req_op[2*gidx +: 2];
   assign g_x  = req_x[32*gidx +: 32];
   assign g_d  = req_d[32*gidx +: 32];

   // The latched request drives the divider directly, so operands stay put until the next grant.
   assign div_op = cur.op;
   assign div_rm = cur.rm;
   assign div_x  = cur.x;
   assign div_d  = cur.d;
   assign rsp_id = IDW'(cur.id);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         timer      <= '0;
         cur        <= '0;
         div_start  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
         cnt_done   <= '0;
         cnt_err    <= '0;
      end else begin
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (any) begin
                  cur.op <= g_op;
                  cur.rm <= req_rm[gidx];
                  cur.x  <= g_x;
                  cur.d  <= (g_op == OP_SQRT) ? 32'd0 : g_d;
                  cur.id <= 3'(gidx);
                  rr_ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
                  if (g_op[1]) begin
                     rsp_result <= QNAN32;
                     rsp_err    <= 1'b1;
                     cnt_err    <= cnt_err + CNTW'(1);
                     rsp_valid  <= 1'b1;
                     state      <= RESP;
                  end else begin
                     div_start <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               timer <= '0;
               state <= BUSY;
            end
            BUSY: begin
               timer <= timer + TW'(1);
               if (div_done) begin
                  rsp_result <= div_result;
                  rsp_err    <= 1'b0;
                  cnt_done   <= cnt_done + CNTW'(1);
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  rsp_result <= QNAN32;
                  rsp_err    <= 1'b1;
                  cnt_err    <= cnt_err + CNTW'(1);
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// tb/tb_fpdiv_arbiter.sv - randomized bench with a cycle-timeline reference model and fpdiv stub
module tb_fpdiv_arbiter;
   import fpdiv_pkg::*;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 64;
   localparam int CNTW    = 16;
   localparam int HANG    = 200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [NREQ-1:0]   req_valid, req_ready, req_rm;
   logic [2*NREQ-1:0] req_op;
   logic [32*NREQ-1:0] req_x, req_d;
   logic              div_start, div_rm, div_done;
   logic [1:0]        div_op;
   logic [31:0]       div_x, div_d, div_result;
   logic              rsp_valid, rsp_ready, rsp_err;
   logic [$clog2(NREQ)-1:0] rsp_id;
   logic [31:0]       rsp_result;
   logic [CNTW-1:0]   cnt_done, cnt_err;

   fpdiv_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
      .req_x(req_x), .req_d(req_d),
      .div_start(div_start), .div_op(div_op), .div_rm(div_rm), .div_x(div_x), .div_d(div_d),
      .div_done(div_done), .div_result(div_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_err(rsp_err),
      .cnt_done(cnt_done), .cnt_err(cnt_err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Bench-defined divider behaviour: two exact IEEE cases, otherwise a scramble of the operands.
   function automatic logic [31:0] fake_fp(input logic [1:0] op, input logic rm,
                                           input logic [31:0] x, input logic [31:0] d);
      if (op == OP_SQRT && x == 32'h40800000) return 32'h40000000;
      if (op == OP_DIV && x == 32'h3F800000 && d == 32'h40000000) return 32'h3F000000;
      return x ^ {d[15:0], d[31:16]} ^ {31'd0, rm} ^ {30'd0, op};
   endfunction

   int          stub_lat = 5;
   int          stub_cnt = 0;
   logic [31:0] stub_res = '0;
   int          n_starts = 0;
   bit          force_done = 1'b0;

   initial begin
      div_done   = 1'b0;
      div_result = '0;
      forever begin
         @(posedge clk);
         #2;
         div_done = 1'b0;
         if (!reset) begin
            stub_cnt = 0;
         end else begin
            if (stub_cnt > 0) begin
               stub_cnt--;
               if (stub_cnt == 0) begin
                  div_done   = 1'b1;
                  div_result = stub_res;
               end
            end
            if (div_start) begin
               stub_cnt = stub_lat;
               stub_res = fake_fp(div_op, div_rm, div_x, div_d);
               n_starts++;
            end
         end
         if (force_done) begin
            div_done   = 1'b1;
            div_result = 32'h12345678;
         end
      end
   end

   // Reference: one outstanding transaction described by its accept cycle and response cycle.
   bit          m_out = 1'b0;
   int          m_acc, m_rsp_cyc, m_id, m_lat, m_ptr = 0;
   logic [1:0]  m_op;
   logic        m_rm, m_err;
   logic [31:0] m_x, m_d, m_res;
   logic [CNTW-1:0] m_cdone = '0, m_cerr = '0;

   bit          ev_acc = 1'b0, ev_hs = 1'b0, prev_rst_low = 1'b1;
   int          ev_id, ev_lat;
   logic [1:0]  ev_op;
   logic        ev_rm;
   logic [31:0] ev_x, ev_d;

   logic              nxt_reset = 1'b1, nxt_rdy = 1'b1;
   logic [NREQ-1:0]   nxt_valid = '0, nxt_rm = '0;
   logic [2*NREQ-1:0] nxt_op = '0;
   logic [32*NREQ-1:0] nxt_x = '0, nxt_d = '0;
   int                nxt_lat = 5;
   bit                nxt_force = 1'b0;

   logic [31:0] lst_res;
   int          lst_id, n_hs = 0;
   logic        lst_err;
   int          acc_q[$];

   task automatic set_port(input int p, input logic [1:0] op, input logic rm,
                           input logic [31:0] x, input logic [31:0] d);
      nxt_op[2*p +: 2] = op;
      nxt_rm[p]        = rm;
      nxt_x[32*p +: 32] = x;
      nxt_d[32*p +: 32] = d;
   endtask

   task automatic step();
      bit exp_rsp, exp_start;
      int g;
      logic [NREQ-1:0] exp_ready;
      if (prev_rst_low) begin
         m_out = 1'b0; m_ptr = 0; m_cdone = '0; m_cerr = '0;
         expect_eq("rst_rsp_result", rsp_result, 32'd0);
         expect_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
         expect_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
         expect_eq("rst_div_x", div_x, 32'd0);
         expect_eq("rst_div_d", div_d, 32'd0);
         expect_eq("rst_div_oprm", {29'd0, div_op, div_rm}, 32'd0);
      end else begin
         if (ev_hs) m_out = 1'b0;
         if (ev_acc) begin
            m_out = 1'b1; m_acc = cyc - 1; m_id = ev_id; m_lat = ev_lat;
            m_op = ev_op; m_rm = ev_rm; m_x = ev_x;
            m_d = (ev_op == OP_SQRT) ? 32'd0 : ev_d;
            m_ptr = (ev_id + 1) % NREQ;
            if (m_op[1]) begin
               m_rsp_cyc = cyc; m_res = QNAN32; m_err = 1'b1;
            end else if (m_lat > TIMEOUT) begin
               m_rsp_cyc = m_acc + 2 + TIMEOUT; m_res = QNAN32; m_err = 1'b1;
            end else begin
               m_rsp_cyc = m_acc + 2 + m_lat; m_res = fake_fp(m_op, m_rm, m_x, m_d); m_err = 1'b0;
            end
         end
      end
      if (m_out && cyc == m_rsp_cyc) begin
         if (m_err) m_cerr++;
         else m_cdone++;
      end
      exp_rsp = m_out && (cyc >= m_rsp_cyc);
      expect_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      if (exp_rsp) begin
         expect_eq("rsp_id", 32'(rsp_id), 32'(m_id));
         expect_eq("rsp_result", rsp_result, m_res);
         expect_eq("rsp_err", 32'(rsp_err), 32'(m_err));
      end
      exp_start = m_out && !m_op[1] && (cyc == m_acc + 1);
      expect_eq("div_start", 32'(div_start), 32'(exp_start));
      if (exp_start) begin
         expect_eq("div_op", 32'(div_op), 32'(m_op));
         expect_eq("div_rm", 32'(div_rm), 32'(m_rm));
         expect_eq("div_x", div_x, m_x);
         expect_eq("div_d", div_d, m_d);
      end
      expect_eq("cnt_done", 32'(cnt_done), 32'(m_cdone));
      expect_eq("cnt_err", 32'(cnt_err), 32'(m_cerr));

      reset = nxt_reset; req_valid = nxt_valid; req_op = nxt_op; req_rm = nxt_rm;
      req_x = nxt_x; req_d = nxt_d; rsp_ready = nxt_rdy; force_done = nxt_force;
      if (!m_out) stub_lat = nxt_lat;
      #1;
      g = -1;
      if (nxt_reset && !m_out) begin
         for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && nxt_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
         end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      expect_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      ev_acc = (g >= 0);
      if (ev_acc) begin
         ev_id = g; ev_lat = stub_lat; ev_op = nxt_op[2*g +: 2]; ev_rm = nxt_rm[g];
         ev_x = nxt_x[32*g +: 32]; ev_d = nxt_d[32*g +: 32];
         acc_q.push_back(g);
      end
      ev_hs = nxt_reset && rsp_valid && rsp_ready;
      if (ev_hs) begin
         lst_res = rsp_result; lst_id = int'(rsp_id); lst_err = rsp_err; n_hs++;
      end
      prev_rst_low = !nxt_reset;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_accept(input int budget);
      int b = 0;
      ev_acc = 1'b0;
      while (!ev_acc && b < budget) begin
         step();
         b++;
      end
      if (!ev_acc) expect_eq("accept_budget", 32'(b), 32'(budget + 1));
      nxt_valid = '0;
   endtask

   task automatic drain(input int budget);
      int b = 0;
      while ((m_out || ev_acc) && b < budget) begin
         step();
         b++;
      end
      if (b >= budget) expect_eq("drain_budget", 32'(b), 32'(budget + 1));
   endtask

   function automatic logic [1:0] rand_op();
      if ($urandom_range(0, 9) == 0) return {1'b1, 1'($urandom_range(0, 1))};
      return {1'b0, 1'($urandom_range(0, 1))};
   endfunction

   initial begin
      int s0, h0;
      reset = 1'b0; req_valid = 2'b11; req_op = '0; req_rm = '0;
      req_x = '0; req_d = '0; rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc = 1;

      // reset held with both requesters valid
      nxt_reset = 1'b0; nxt_valid = 2'b11;
      repeat (3) step();
      nxt_reset = 1'b1; nxt_valid = '0;
      step();

      // single sqrt on port 0, 20-cycle divider
      s0 = n_starts;
      set_port(0, OP_SQRT, 1'b0, 32'h40800000, 32'hDEADBEEF);
      nxt_valid = 2'b01; nxt_lat = 20; nxt_rdy = 1'b1;
      wait_accept(10);
      drain(60);
      expect_eq("single_res", lst_res, 32'h40000000);
      expect_eq("single_id", 32'(lst_id), 32'd0);
      expect_eq("single_err", 32'(lst_err), 32'd0);
      expect_eq("single_cnt_done", 32'(cnt_done), 32'd1);
      expect_eq("single_starts", 32'(n_starts - s0), 32'd1);

      // fairness after a fresh reset
      nxt_reset = 1'b0;
      repeat (2) step();
      nxt_reset = 1'b1;
      set_port(0, OP_SQRT, 1'b0, 32'h40800000, 32'd0);
      set_port(1, OP_DIV, 1'b0, 32'h3F800000, 32'h40000000);
      nxt_valid = 2'b11; nxt_lat = 5;
      acc_q.delete();
      for (int b = 0; b < 200 && acc_q.size() < 4; b++) begin
         step();
         if (ev_hs && lst_id == 1) expect_eq("fair_port1_res", lst_res, 32'h3F000000);
      end
      nxt_valid = '0;
      drain(40);
      for (int i = 0; i < 4; i++) begin
         expect_eq("fair_grant", (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFFFFFF, 32'(i % 2));
      end

      // watchdog: divider never answers
      h0 = int'(cnt_err);
      set_port(1, OP_DIV, 1'b1, 32'h40400000, 32'h3F800000);
      nxt_valid = 2'b10; nxt_lat = HANG;
      wait_accept(10);
      drain(TIMEOUT + 20);
      expect_eq("tmo_err", 32'(lst_err), 32'd1);
      expect_eq("tmo_res", lst_res, QNAN32);
      expect_eq("tmo_cnt_err", 32'(cnt_err), 32'(h0 + 1));

      // done on the last allowed cycle still counts as a normal completion
      nxt_valid = 2'b10; nxt_lat = TIMEOUT;
      wait_accept(10);
      drain(TIMEOUT + 20);
      expect_eq("tmo_edge_err", 32'(lst_err), 32'd0);

      // illegal op never starts the divider
      s0 = n_starts;
      set_port(0, 2'b10, 1'b0, 32'h11111111, 32'h22222222);
      nxt_valid = 2'b01;
      wait_accept(10);
      drain(10);
      expect_eq("illegal_starts", 32'(n_starts - s0), 32'd0);
      expect_eq("illegal_err", 32'(lst_err), 32'd1);

      // backpressure with both requesters pending
      set_port(0, OP_DIV, 1'b0, 32'h40A00000, 32'h40000000);
      nxt_valid = 2'b11; nxt_lat = 3; nxt_rdy = 1'b0;
      wait_accept(10);
      nxt_valid = 2'b11;
      repeat (15) step();
      nxt_valid = '0; nxt_rdy = 1'b1;
      drain(20);

      // reset in BUSY, then a stray done
      h0 = n_hs;
      nxt_valid = 2'b01; nxt_lat = HANG;
      wait_accept(10);
      repeat (5) step();
      nxt_reset = 1'b0;
      step();
      nxt_reset = 1'b1; nxt_force = 1'b1;
      step();
      nxt_force = 1'b0;
      repeat (10) step();
      expect_eq("midrst_no_rsp", 32'(n_hs - h0), 32'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         nxt_valid = NREQ'($urandom_range(0, 3));
         for (int p = 0; p < NREQ; p++) set_port(p, rand_op(), 1'($urandom_range(0, 1)), $urandom, $urandom);
         nxt_rdy = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 11);
         nxt_lat = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT + 1 : (r == 2) ? HANG : $urandom_range(1, 12);
         step();
      end
      nxt_valid = '0; nxt_rdy = 1'b1;
      drain(TIMEOUT + 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
